// File: rtl/gray_pkg.sv
// Shared types and Gray helpers for the up/down Gray counter.
// Helpers are width-agnostic: callers zero-extend to gray_word_t.
package gray_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } gray_state_t;

  localparam int GRAY_MAXW = 64;

  typedef logic [GRAY_MAXW-1:0] gray_word_t;

  // Zero high bits stay zero, so any narrower value
  // can be converted after zero-extension.
  function automatic gray_word_t bin2gray(
    input gray_word_t b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(
    input gray_word_t g
  );
    gray_word_t b;
    b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
    for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_ud.sv
// Up/down binary counter with coherent registered Gray output,
// zero flag, wrap pulse and optional one-shot stop.
// Ports: clk, rst (async high), en, up, clr, ld, ld_val[CBITS]
//   -> cnt[CBITS], gray_c[CBITS], sig, wrap, done.
// Macro GRAY_COUNTER_UD_PROPS_EN embeds SVA property checks.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int               CBITS   = 14,
  parameter bit               ONESHOT = 1'b0,
  parameter logic [CBITS-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  logic [CBITS-1:0] ld_val,
  output logic [CBITS-1:0] cnt,
  output logic [CBITS-1:0] gray_c,
  output logic             sig,
  output logic             wrap,
  output logic             done
);

  localparam logic [CBITS-1:0] ONES = '1;
  localparam logic [CBITS-1:0] RST_GRAY =
    CBITS'(bin2gray(gray_word_t'(RST_VAL)));

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  gray_state_t      state_q, state_d;

  // Gray is derived from the next binary value so both
  // registers update on the same edge (no lag).
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    priority case (1'b1)
      clr: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      ld: begin
        cnt_d   = ld_val;
        state_d = RUN;
      end
      (en && state_q == RUN): begin
        if (up) begin
          cnt_d  = cnt_q + 1'b1;
          wrap_d = (cnt_q == ONES);
        end else begin
          cnt_d  = cnt_q - 1'b1;
          wrap_d = (cnt_q == '0);
        end
        if (ONESHOT && wrap_d) begin
          state_d = DONE;
        end
      end
      default: ;
    endcase
    gray_d = CBITS'(bin2gray(gray_word_t'(cnt_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= RST_VAL;
      gray_q  <= RST_GRAY;
      wrap_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign cnt    = cnt_q;
  assign gray_c = gray_q;
  assign wrap   = wrap_q;
  assign done   = (state_q == DONE);
  assign sig    = (cnt_q == '0) & ~rst;

`ifdef GRAY_COUNTER_UD_PROPS_EN
  a_coherent: assert property (
    @(posedge clk) disable iff (rst)
    gray_q == (cnt_q ^ (cnt_q >> 1)));

  a_max_one_bit: assert property (
    @(posedge clk) disable iff (rst)
    !$past(clr || ld) |->
      $countones(gray_q ^ $past(gray_q)) <= 1);

  a_step_one_bit: assert property (
    @(posedge clk) disable iff (rst)
    (en && !clr && !ld && state_q == RUN) |=>
      $countones(gray_q ^ $past(gray_q)) == 1);

  a_hold_zero: assert property (
    @(posedge clk) disable iff (rst)
    (!clr && !ld && (!en || state_q == DONE)) |=>
      gray_q == $past(gray_q));

  a_wrap_single: assert property (
    @(posedge clk) disable iff (rst)
    wrap_q |=> !wrap_q);

  a_roundtrip: assert property (
    @(posedge clk) disable iff (rst)
    CBITS'(gray2bin(gray_word_t'(gray_q))) == cnt_q);

  if (!ONESHOT) begin : g_live
    a_sig_live: assert property (
      @(posedge clk)
      (s_eventually always (!rst && en && up))
        implies (always s_eventually sig));
  end
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Self-checking bench for gray_counter_ud.
// Three instances share stimulus; an arithmetic model tracks each.
module tb_gray_counter_ud;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [13:0] ld_val = '0;

  logic [3:0]  c0, g0, c1, g1;
  logic [13:0] c2, g2;
  logic        s0, s1, s2, w0, w1, w2, d0, d1, d2;

  int checks = 0;
  int failures = 0;

  // model parameters and state per instance
  int W[3]  = '{4, 4, 14};
  int OS[3] = '{0, 1, 0};
  int RV[3] = '{0, 3, 5};
  int mc[3];
  int mw[3];
  int md[3];

  always #5 clk = ~clk;

  gray_counter_ud #(.CBITS(4), .ONESHOT(1'b0), .RST_VAL(4'd0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val[3:0]), .cnt(c0), .gray_c(g0), .sig(s0),
    .wrap(w0), .done(d0));

  gray_counter_ud #(.CBITS(4), .ONESHOT(1'b1), .RST_VAL(4'd3)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val[3:0]), .cnt(c1), .gray_c(g1), .sig(s1),
    .wrap(w1), .done(d1));

  gray_counter_ud #(.CBITS(14), .ONESHOT(1'b0), .RST_VAL(14'd5)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .cnt(c2), .gray_c(g2), .sig(s2),
    .wrap(w2), .done(d2));

  function automatic int cnt_of(int k);
    case (k)
      0: return int'(c0);
      1: return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  function automatic int gray_of(int k);
    case (k)
      0: return int'(g0);
      1: return int'(g1);
      default: return int'(g2);
    endcase
  endfunction

  function automatic int bit_of(int k, int which);
    logic v;
    case (which)
      0: v = (k == 0) ? s0 : (k == 1) ? s1 : s2;
      1: v = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      default: v = (k == 0) ? d0 : (k == 1) ? d1 : d2;
    endcase
    return int'(v);
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mc[k] = RV[k];
      mw[k] = 0;
      md[k] = 0;
    end
  endtask

  // Model of one clock edge from the behavioural rules.
  task automatic model_step();
    int m;
    for (int k = 0; k < 3; k++) begin
      m = 1 << W[k];
      if (clr) begin
        mc[k] = 0; mw[k] = 0; md[k] = 0;
      end else if (ld) begin
        mc[k] = int'(ld_val) % m; mw[k] = 0; md[k] = 0;
      end else if (en && md[k] == 0) begin
        if (up) begin
          mw[k] = (mc[k] == m - 1) ? 1 : 0;
          mc[k] = (mc[k] + 1) % m;
        end else begin
          mw[k] = (mc[k] == 0) ? 1 : 0;
          mc[k] = (mc[k] + m - 1) % m;
        end
        if (OS[k] != 0 && mw[k] != 0) md[k] = 1;
      end else begin
        mw[k] = 0;
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s d%0d cnt", tag, k), cnt_of(k), mc[k]);
      check($sformatf("%s d%0d gray", tag, k), gray_of(k),
            mc[k] ^ (mc[k] >> 1));
      check($sformatf("%s d%0d sig", tag, k), bit_of(k, 0),
            (mc[k] == 0 && !rst) ? 1 : 0);
      check($sformatf("%s d%0d wrap", tag, k), bit_of(k, 1), mw[k]);
      check($sformatf("%s d%0d done", tag, k), bit_of(k, 2), md[k]);
    end
  endtask

  task automatic step(string tag, logic e, logic u, logic c,
                      logic l, logic [13:0] v);
    en = e; up = u; clr = c; ld = l; ld_val = v;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("reset");
  endtask

  typedef struct {
    logic       e, u, c, l;
    logic [3:0] v;
    int         ec, eg, ew;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  0,  0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 15,  8, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 15,  8, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0,  0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1,  1, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  0,  0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  9, 13, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  8, 12, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 15, 8, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  0,  0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 15, 8, 0};

    #2;
    do_reset();

    // 16 up-steps from 0 on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      step("up16", 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("up16 cnt", int'(c0), (i + 1) % 16);
      check("up16 wrap", int'(w0), (i == 15) ? 1 : 0);
    end
    check("up16 sig at 0", int'(s0), 1);

    for (int i = 0; i < 11; i++) begin
      step("tbl", tbl[i].e, tbl[i].u, tbl[i].c, tbl[i].l,
           {10'd0, tbl[i].v});
      check($sformatf("tbl%0d cnt", i), int'(c0), tbl[i].ec);
      check($sformatf("tbl%0d gray", i), int'(g0), tbl[i].eg);
      check($sformatf("tbl%0d wrap", i), int'(w0), tbl[i].ew);
    end

    // one-shot stop and restart
    step("os", 1'b0, 1'b0, 1'b0, 1'b1, 14'd14);
    step("os", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("os pre cnt", int'(c1), 15);
    step("os", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("os wrap cnt", int'(c1), 0);
    check("os wrap", int'(w1), 1);
    check("os done", int'(d1), 1);
    for (int i = 0; i < 5; i++) begin
      step("os hold", 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("os hold cnt", int'(c1), 0);
      check("os hold done", int'(d1), 1);
      check("os hold wrap", int'(w1), 0);
      check("os hold sig", int'(s1), 1);
    end
    step("os", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("os clr done", int'(d1), 0);
    step("os", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("os restart cnt", int'(c1), 1);

    // asynchronous reset mid-cycle
    step("ar", 1'b0, 1'b0, 1'b0, 1'b1, 14'd7);
    check("ar pre cnt", int'(c1), 7);
    #2;
    rst = 1'b1;
    #1;
    check("ar cnt", int'(c1), 3);
    check("ar gray", int'(g1), 2);
    check("ar sig0", int'(s0), 0);
    check("ar cnt0", int'(c0), 0);
    check("ar cnt2", int'(c2), 5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("ar post");
    step("ar run", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("ar resume", int'(c1), 4);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step("rnd",
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 23) == 0),
             14'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter_ud.md
Name: gray_counter_ud

Overview:
- Parametrised successor of the single-width free-running Gray counter.
- Binary up/down counter with enable, synchronous clear and parallel load.
- Gray output is registered and always coherent with the binary count, with no one-cycle lag.
- Adds a zero indicator, a wrap pulse and an optional one-shot mode. Used as a Gray-coded pointer or timebase source in liveness benchmark designs.

Parameters:
- CBITS, 14, counter width in bits (>=2).
- ONESHOT, 0, 1 = stop in DONE after the first wrap; 0 = free-running.
- RST_VAL, 0, binary value loaded on reset (CBITS wide).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- ld  input  1  synchronous load of ld_val
- ld_val  input  CBITS  binary load value
- cnt  output  CBITS  registered binary count
- gray_c  output  CBITS  registered Gray code, always equal to cnt ^ (cnt >> 1)
- sig  output  1  combinational: (cnt == 0) & ~rst
- wrap  output  1  registered one-cycle pulse on wrap-around
- done  output  1  high while in the DONE state (always 0 when ONESHOT=0)

Behaviour:
- Reset (asynchronous, active-high):
  - cnt = RST_VAL, gray_c = bin2gray(RST_VAL), wrap = 0, state = RUN, done = 0.
  - sig is forced to 0 while rst is high.
- Per-cycle priority: clr > ld > en. Inputs are sampled on the rising clk edge.
- clr: cnt <= 0, gray_c <= 0, wrap <= 0, state <= RUN.
- ld: cnt <= ld_val, gray_c <= bin2gray(ld_val), wrap <= 0, state <= RUN.
- en=1 in RUN:
  - up=1: cnt <= cnt+1, modulo 2^CBITS.
  - up=0: cnt <= cnt-1, modulo 2^CBITS.
  - gray_c <= bin2gray(next cnt), updated on the same edge as cnt.
- en=0 (or state DONE) with no clr/ld: cnt, gray_c and state hold; wrap <= 0.
- Wrap:
  - Defined as a counting step from all-ones to 0 (up), or from 0 to all-ones (down).
  - On that edge, wrap <= 1 for exactly one cycle.
  - clr or ld never produces wrap, even if the value jumps across the boundary.
- FSM states:
  - RUN -> DONE: ONESHOT=1 and a wrap step occurs. cnt is left at the post-wrap value (0 for up, all-ones for down), and wrap still pulses.
  - DONE -> RUN: only on clr or ld.
  - ONESHOT=0: the FSM never leaves RUN.
- Gray property:
  - Every counting step changes exactly one bit of gray_c, including both wrap steps.
  - A direction change mid-count is legal and also changes exactly one bit.
- Simultaneous clr and ld: clr wins and ld_val is ignored.
- Reset asserted mid-count: takes effect immediately and asynchronously. On deassertion, counting resumes from RST_VAL at the next enabled edge.
- sig behaviour: combinational from cnt. It stays high for every cycle cnt==0, including held cycles and the DONE state.

Optional Feature:
- Macro: GRAY_COUNTER_UD_PROPS_EN.
- When defined, the module embeds SVA checks, clocked @(posedge clk) and disabled during rst:
  - gray_c == cnt ^ (cnt >> 1) on every cycle.
  - $countones(gray_c ^ $past(gray_c)) <= 1 on every cycle; it is 1 on counting steps, 0 on holds, and unconstrained after clr/ld.
  - wrap is never high on two consecutive cycles.
  - Liveness, ONESHOT=0 only: s_eventually (!rst && en && up) holding forever implies that sig recurs infinitely often.
- When undefined: no assertions and identical RTL behaviour.

Decomposition:
- Package gray_pkg provides:
  - typedef enum logic [0:0] {RUN, DONE} gray_state_t.
  - Functions bin2gray and gray2bin, parametrised by width through a parameterised class static method or width-agnostic logic.
- No sub-module. Next-count arithmetic, the FSM and output registers sit in one always_ff block, with one always_comb block for the next value.

Test Plan:
- CBITS=4, rst pulse, then en=1, up=1 for 16 cycles:
  - cnt goes 0..15 then 0.
  - gray_c follows 0,1,3,2,6,...,8,0.
  - wrap is high only in the cycle after the 15->0 step.
  - sig is high at cnt 0.
- CBITS=4, load 0, then up=0 for one cycle:
  - cnt = 15, gray_c = 8'h8 (4'b1000), wrap pulses once.
- CBITS=4, ONESHOT=1, ld_val=14, en=1, up=1:
  - cnt goes 15 -> 0, wrap = 1, done = 1.
  - cnt stays 0 for 5 more enabled cycles.
  - clr then en returns to RUN and cnt increments to 1.
- clr and ld asserted together with ld_val=9:
  - cnt = 0, gray_c = 0, no wrap.
- Assert rst asynchronously mid-cycle at cnt=7 with RST_VAL=3:
  - cnt = 3 and gray_c = 2 before the next edge.
  - sig = 0 while rst is high.
- Random en/up/ld/clr for 10k cycles with GRAY_COUNTER_UD_PROPS_EN defined: no assertion failures.
